// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: frames raw words (start, LSB-first data,
// optional parity, 1-2 stop bits) at a runtime clocks-per-bit divisor.
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_TWO  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH:0]   STOP_ONE = (DIV_WIDTH + 1)'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH:0]   stop_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;

  logic [DIV_WIDTH-1:0] div_last;
  logic [DIV_WIDTH:0]   stop_last;
  logic                 bit_end;

  assign div_last  = div_q - DIV_ONE;
  assign bit_end   = (baud_cnt == div_last);
  // Stop bits are timed as one long period so two stop bits need no extra state.
  assign stop_last = (STOP_BITS == 2) ? ({div_q, 1'b0} - STOP_ONE)
                                      : ({1'b0, div_q} - STOP_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_q    <= '0;
      baud_cnt <= '0;
      stop_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            shreg    <= s_data;
            div_q    <= (baud_div < DIV_TWO) ? DIV_TWO : baud_div;
            par_q    <= (PARITY == 1) ? ~^s_data : ^s_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + DIV_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_idx == LAST_IDX) begin
              stop_cnt <= '0;
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end else begin
            baud_cnt <= baud_cnt + DIV_ONE;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            stop_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + DIV_ONE;
          end
        end
        S_STOP: begin
          if (stop_cnt == stop_last) begin
            stop_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            stop_cnt <= stop_cnt + STOP_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (state)
      S_START:  tx_out = 1'b0;
      S_DATA:   tx_out = shreg[0];
      S_PARITY: tx_out = par_q;
      default:  tx_out = 1'b1;
    endcase
  end

  assign s_ready    = (state == S_IDLE);
  assign tx_busy    = (state != S_IDLE);
  assign frame_done = (state == S_STOP) && (stop_cnt == stop_last);

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three parameter variants checked every cycle
// against a queue-based expected-waveform model plus literal frame checks.
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic [2:0]  rs;
  logic [2:0]  sv;
  logic [15:0] bd [3];
  logic [7:0]  sd0;
  logic [6:0]  sd1;
  logic [8:0]  sd2;
  logic [2:0]  rdy, tx, busy, done;

  int errors = 0;
  int nchecks = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) dut0 (
    .clk(clk), .rst(rs[0]), .baud_div(bd[0]), .s_valid(sv[0]), .s_data(sd0),
    .s_ready(rdy[0]), .tx_out(tx[0]), .tx_busy(busy[0]), .frame_done(done[0]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DIV_WIDTH(16)) dut1 (
    .clk(clk), .rst(rs[1]), .baud_div(bd[1]), .s_valid(sv[1]), .s_data(sd1),
    .s_ready(rdy[1]), .tx_out(tx[1]), .tx_busy(busy[1]), .frame_done(done[1]));
  uart_tx_param #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .DIV_WIDTH(16)) dut2 (
    .clk(clk), .rst(rs[2]), .baud_div(bd[2]), .s_valid(sv[2]), .s_data(sd2),
    .s_ready(rdy[2]), .tx_out(tx[2]), .tx_busy(busy[2]), .frame_done(done[2]));

  function automatic int nbits_of(int d);
    return (d == 0) ? 8 : (d == 1) ? 7 : 9;
  endfunction
  function automatic int par_of(int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction
  function automatic int stop_of(int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int data_of(int d);
    if (d == 0) return int'(sd0);
    if (d == 1) return int'(sd1);
    return int'(sd2);
  endfunction

  task automatic set_data(int d, int v);
    case (d)
      0: sd0 = v[7:0];
      1: sd1 = v[6:0];
      default: sd2 = v[8:0];
    endcase
  endtask

  typedef struct packed { logic tx; logic done; } ent_t;
  ent_t q [3][$];
  bit   armed [3];

  // Expected line level per clock for one whole frame, built from the bit list.
  task automatic push_frame(int d, int data, int dv);
    int nb, par, st, len, ones;
    bit pbit, v;
    ent_t e;
    nb = nbits_of(d); par = par_of(d); st = stop_of(d);
    len = 1 + nb + ((par != 0) ? 1 : 0) + st;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += data[i];
    pbit = (par == 2) ? bit'(ones % 2) : bit'(1 - (ones % 2));
    for (int b = 0; b < len; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= nb) v = data[b-1];
      else if (par != 0 && b == nb + 1) v = pbit;
      else v = 1'b1;
      for (int c = 0; c < dv; c++) begin
        e.tx = v;
        e.done = (b == len - 1) && (c == dv - 1);
        q[d].push_back(e);
      end
    end
  endtask

  initial begin
    armed = '{0, 0, 0};
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rs[d]) begin
          q[d].delete();
          armed[d] = 1'b1;
        end else if (q[d].size() != 0) begin
          void'(q[d].pop_front());
        end else if (sv[d]) begin
          push_frame(d, data_of(d), (bd[d] < 16'd2) ? 2 : int'(bd[d]));
        end
      end
    end
  end

  task automatic check_bit(string name, int d, logic act, logic exp);
    nchecks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %b expected %b", name, d, $time, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    nchecks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    logic etx, edn, ebz;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (armed[d]) begin
          if (q[d].size() == 0) begin
            etx = 1'b1; edn = 1'b0; ebz = 1'b0;
          end else begin
            etx = q[d][0].tx; edn = q[d][0].done; ebz = 1'b1;
          end
          check_bit("tx_out", d, tx[d], etx);
          check_bit("tx_busy", d, busy[d], ebz);
          check_bit("frame_done", d, done[d], edn);
          check_bit("s_ready", d, rdy[d], !ebz);
        end
      end
    end
  end

  task automatic send(int d, int data, int dv);
    sv[d] = 1'b1;
    set_data(d, data);
    bd[d] = 16'(dv);
    @(posedge clk);
    #1;
    sv[d] = 1'b0;
  endtask

  // Samples one frame starting at its first START clock; bit i at mid-period.
  task automatic capture(int d, int nbits, int dv, output int bits, output int busy_n,
                         output int done_at);
    bits = 0; busy_n = 0; done_at = -1;
    for (int c = 0; c < nbits * dv; c++) begin
      @(negedge clk);
      if (busy[d]) busy_n++;
      if (done[d] && done_at < 0) done_at = c + 1;
      if (c % dv == dv / 2) bits = bits | (int'(tx[d]) << (c / dv));
    end
    @(negedge clk);
    check_bit("ready_after_frame", d, rdy[d], 1'b1);
  endtask

  initial begin
    int bits, bn, dn;
    rs = '1; sv = '0;
    bd = '{16'd4, 16'd4, 16'd4};
    sd0 = '0; sd1 = '0; sd2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rs = '0;
    @(negedge clk);
    check_bit("reset_tx", 0, tx[0], 1'b1);
    check_bit("reset_ready", 0, rdy[0], 1'b1);

    send(0, 'hA5, 4);
    capture(0, 10, 4, bits, bn, dn);
    check_int("a5_bits", bits, 'h34A);
    check_int("a5_busy", bn, 40);
    check_int("a5_done", dn, 40);

    send(1, 'h07, 3);
    capture(1, 11, 3, bits, bn, dn);
    check_int("even_par_bits", bits, 'h70E);
    check_int("even_par_busy", bn, 33);
    check_int("even_par_done", dn, 33);

    send(2, 'h07, 5);
    capture(2, 12, 5, bits, bn, dn);
    check_int("odd_par_bits", bits, 'h80E);
    check_int("odd_par_done", dn, 60);

    sv[0] = 1'b1; sd0 = 8'h00; bd[0] = 16'd2;
    @(posedge clk);
    #1;
    sd0 = 8'hFF;
    repeat (21) @(negedge clk);
    check_bit("b2b_gap_ready", 0, rdy[0], 1'b1);
    check_bit("b2b_gap_tx", 0, tx[0], 1'b1);
    @(posedge clk);
    #1;
    sv[0] = 1'b0;
    capture(0, 10, 2, bits, bn, dn);
    check_int("b2b_second_bits", bits, 'h3FE);
    check_int("b2b_second_busy", bn, 20);

    send(0, 'h5A, 4);
    repeat (17) @(posedge clk);
    #1;
    rs[0] = 1'b1;
    @(posedge clk);
    #1;
    rs[0] = 1'b0;
    @(negedge clk);
    check_bit("abort_tx", 0, tx[0], 1'b1);
    check_bit("abort_busy", 0, busy[0], 1'b0);
    check_bit("abort_ready", 0, rdy[0], 1'b1);
    check_bit("abort_done", 0, done[0], 1'b0);
    send(0, 'hC3, 3);
    capture(0, 10, 3, bits, bn, dn);
    check_int("after_abort_bits", bits, 'h386);

    send(0, 'h3C, 0);
    capture(0, 10, 2, bits, bn, dn);
    check_int("div0_bits", bits, 'h278);
    check_int("div0_busy", bn, 20);
    send(0, 'h3C, 1);
    capture(0, 10, 2, bits, bn, dn);
    check_int("div1_busy", bn, 20);

    send(0, 'h96, 4);
    bd[0] = 16'd8;
    capture(0, 10, 4, bits, bn, dn);
    check_int("midchange_busy", bn, 40);
    check_int("midchange_bits", bits, 'h32C);
    send(0, 'h96, int'(bd[0]));
    capture(0, 10, 8, bits, bn, dn);
    check_int("newdiv_busy", bn, 80);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        sv[d] = ($urandom_range(0, 3) != 0);
        set_data(d, int'($urandom));
        bd[d] = 16'($urandom_range(0, 6));
        rs[d] = ($urandom_range(0, 399) == 0);
      end
    end
    sv = '0; rs = '0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
